// File: rtl/grf_hazard_ctrl_pkg.sv
// Shared types and encodings for the GRF hazard scheduler.
// Used by grf_hazard_ctrl and md_busy_timer.
package grf_hazard_ctrl_pkg;

    localparam int T_W = 2;

    typedef logic [T_W-1:0] t_cnt_t;
    typedef logic [4:0]     reg_idx_t;

    localparam t_cnt_t TUSE_NONE = 2'd3;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;

    localparam logic [1:0] MD_NONE = 2'd0;
    localparam logic [1:0] MD_MULT = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;

    typedef struct packed {
        reg_idx_t wa;
        t_cnt_t   tnew;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '{wa: 5'd0, tnew: 2'd0};

    // Entry as seen one stage later: Tnew counts down, never below 0.
    function automatic stage_t age(input stage_t s);
        stage_t r;
        r.wa   = s.wa;
        r.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/grf_hazard_ctrl_md_busy_timer.sv
// MDU busy window: loads on mult/div issue, counts down to 0.
// md_busy is high while the count is nonzero.
module md_busy_timer
    import grf_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue,
    input  logic [1:0] md_op,
    output logic       md_busy
);

    logic [CNT_W-1:0] cnt;

    // A load on the same edge as a decrement wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (issue && md_op == MD_MULT) begin
            cnt <= CNT_W'(MULT_CYCLES);
        end else if (issue && md_op == MD_DIV) begin
            cnt <= CNT_W'(DIV_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/grf_hazard_ctrl.sv
// GRF hazard scheduler: Tuse/Tnew stall, bubble and D-stage forwarding.
// Define HAZARD_STATS_EN to build the stall_cnt statistic counter.
module grf_hazard_ctrl
    import grf_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  d_wa,
    input  logic [1:0]  d_tnew,
    input  logic [1:0]  d_md_op,
    input  logic        d_md_use,
    output logic        stall,
    output logic        e_flush,
    output logic [1:0]  fwd_rs_sel,
    output logic [1:0]  fwd_rt_sel,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    // stg[0]=E, stg[1]=M, stg[2]=W
    stage_t stg [3];
    logic   data_hz;

    function automatic logic raw(input stage_t st,
                                 input reg_idx_t src,
                                 input t_cnt_t tuse);
        return (src != 5'd0) && (st.wa == src) && (st.tnew > tuse);
    endfunction

    function automatic logic [1:0] fwd(input stage_t e,
                                       input stage_t m,
                                       input reg_idx_t src);
        logic       hit_e;
        logic       hit_m;
        logic [1:0] sel;
        hit_e = (src != 5'd0) && (e.wa == src) && (e.tnew == 2'd0);
        hit_m = (src != 5'd0) && (m.wa == src) && (m.tnew == 2'd0);
        sel   = FWD_GRF;
        priority case (1'b1)
            hit_e:   sel = FWD_E;
            hit_m:   sel = FWD_M;
            default: sel = FWD_GRF;
        endcase
        return sel;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stg[0] <= STAGE_EMPTY;
            stg[1] <= STAGE_EMPTY;
            stg[2] <= STAGE_EMPTY;
        end else begin
            stg[0] <= (d_valid && !stall) ?
                      '{wa: d_wa, tnew: d_tnew} : STAGE_EMPTY;
            stg[1] <= age(stg[0]);
            stg[2] <= age(stg[1]);
        end
    end

    // W is absent here: the GRF bypasses same-cycle writes itself.
    always_comb begin
        data_hz = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_hz = data_hz
                    | raw(stg[i], d_rs, d_tuse_rs)
                    | raw(stg[i], d_rt, d_tuse_rt);
        end
    end

    assign stall      = d_valid && (data_hz || (d_md_use && md_busy));
    assign e_flush    = stall;
    assign fwd_rs_sel = fwd(stg[0], stg[1], d_rs);
    assign fwd_rt_sel = fwd(stg[0], stg[1], d_rt);

    md_busy_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .issue  (d_valid && !stall),
        .md_op  (d_md_op),
        .md_busy(md_busy)
    );

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (stall) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Directed bench for grf_hazard_ctrl.
// Expected stall_cnt follows HAZARD_STATS_EN.
module tb_grf_hazard_ctrl;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [1:0]  d_tuse_rs;
    logic [1:0]  d_tuse_rt;
    logic [4:0]  d_wa;
    logic [1:0]  d_tnew;
    logic [1:0]  d_md_op;
    logic        d_md_use;
    logic        stall;
    logic        e_flush;
    logic [1:0]  fwd_rs_sel;
    logic [1:0]  fwd_rt_sel;
    logic        md_busy;
    logic [31:0] stall_cnt;

    int checks = 0;
    int failures = 0;
    int exp_stalls = 0;

    grf_hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .d_valid   (d_valid),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_wa      (d_wa),
        .d_tnew    (d_tnew),
        .d_md_op   (d_md_op),
        .d_md_use  (d_md_use),
        .stall     (stall),
        .e_flush   (e_flush),
        .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel),
        .md_busy   (md_busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge; outputs checked 1 unit later.
    task automatic drive(input logic v, input logic [4:0] rs,
                         input logic [1:0] urs, input logic [4:0] rt,
                         input logic [1:0] urt, input logic [4:0] wa,
                         input logic [1:0] tn, input logic [1:0] op,
                         input logic use_md);
        d_valid   = v;
        d_rs      = rs;
        d_tuse_rs = urs;
        d_rt      = rt;
        d_tuse_rt = urt;
        d_wa      = wa;
        d_tnew    = tn;
        d_md_op   = op;
        d_md_use  = use_md;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({stall, e_flush, fwd_rs_sel, fwd_rt_sel, md_busy} !== 7'd0) begin
            failures++;
            $display("FAIL reset_outs got=%b want=0",
                     {stall, e_flush, fwd_rs_sel, fwd_rt_sel, md_busy});
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d want=0", stall_cnt);
        end
        exp_stalls = 0;
    endtask

    task automatic test_lw_beq();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (stall !== 1'b1 || e_flush !== 1'b1) begin
                failures++;
                $display("FAIL lw_beq_stall%0d got=%b%b want=11",
                         c, stall, e_flush);
            end
            exp_stalls++;
            tick();
        end
        checks++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd0) begin
            failures++;
            $display("FAIL lw_beq_release got stall=%b fwd=%0d want 0/0",
                     stall, fwd_rs_sel);
        end
        tick();
        idle(3);
    endtask

    task automatic test_lw_addu();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 2'd1, 5'd2, 2'd1, 5'd3, 2'd1, 2'd0, 1'b0);
        checks++;
        if (stall !== 1'b1 || e_flush !== 1'b1) begin
            failures++;
            $display("FAIL lw_addu_stall got=%b%b want=11", stall, e_flush);
        end
        exp_stalls++;
        tick();
        checks++;
        if (stall !== 1'b0 || e_flush !== 1'b0 || fwd_rs_sel !== 2'd0) begin
            failures++;
            $display("FAIL lw_addu_release got=%b%b fwd=%0d want=00 fwd=0",
                     stall, e_flush, fwd_rs_sel);
        end
        tick();
        idle(3);
    endtask

    task automatic test_jal_jr();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0);
        checks++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd1) begin
            failures++;
            $display("FAIL jal_jr_e got stall=%b fwd=%0d want 0/1",
                     stall, fwd_rs_sel);
        end
        tick();
        idle(3);
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd31, 2'd0, 5'd31, 2'd1, 5'd0, 2'd0, 2'd0, 1'b0);
        checks++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd2 || fwd_rt_sel !== 2'd2) begin
            failures++;
            $display("FAIL jal_nop_jr_m got stall=%b rs=%0d rt=%0d want 0/2/2",
                     stall, fwd_rs_sel, fwd_rt_sel);
        end
        tick();
        idle(3);
    endtask

    task automatic test_youngest_wins();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd0, 2'd0, 1'b0);
        tick();
        tick();
        drive(1'b1, 5'd0, 2'd3, 5'd5, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0);
        checks++;
        if (stall !== 1'b0 || fwd_rt_sel !== 2'd1 || fwd_rs_sel !== 2'd0) begin
            failures++;
            $display("FAIL youngest got stall=%b rt=%0d rs=%0d want 0/1/0",
                     stall, fwd_rt_sel, fwd_rs_sel);
        end
        tick();
        idle(3);
    endtask

    task automatic test_mdu(input logic [1:0] op, input int n, input string nm);
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, op, 1'b1);
        checks++;
        if (stall !== 1'b0 || md_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_issue got stall=%b busy=%b want 0/0",
                     nm, stall, md_busy);
        end
        tick();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 2'd0, 1'b1);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (stall !== 1'b1 || md_busy !== 1'b1) begin
                failures++;
                $display("FAIL %s_wait%0d got stall=%b busy=%b want 1/1",
                         nm, c, stall, md_busy);
            end
            exp_stalls++;
            tick();
        end
        checks++;
        if (stall !== 1'b0 || md_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_release got stall=%b busy=%b want 0/0",
                     nm, stall, md_busy);
        end
        tick();
        idle(2);
    endtask

    task automatic test_md_reserved();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd3, 1'b1);
        tick();
        idle(0);
        checks++;
        if (md_busy !== 1'b0) begin
            failures++;
            $display("FAIL md_reserved got busy=%b want 0", md_busy);
        end
        idle(1);
    endtask

    task automatic test_zero_and_invalid();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0);
        checks++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
            failures++;
            $display("FAIL zero_reg got stall=%b rs=%0d rt=%0d want 0/0/0",
                     stall, fwd_rs_sel, fwd_rt_sel);
        end
        tick();
        idle(3);
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 2'd0, 1'b0);
        tick();
        drive(1'b0, 5'd1, 2'd0, 5'd1, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0);
        checks++;
        if (stall !== 1'b0 || e_flush !== 1'b0) begin
            failures++;
            $display("FAIL invalid_gate got=%b%b want=00", stall, e_flush);
        end
        idle(3);
    endtask

    task automatic test_stats();
        checks++;
        if (stall_cnt !== (STATS ? 32'(exp_stalls) : 32'd0)) begin
            failures++;
            $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt,
                     STATS ? exp_stalls : 0);
        end
    endtask

    task automatic test_reset_mid_mult();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 2'd1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 2'd0, 1'b1);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre got stall=%b want 1", stall);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (md_busy !== 1'b0 || stall !== 1'b0 || stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid got busy=%b stall=%b cnt=%0d want 0/0/0",
                     md_busy, stall, stall_cnt);
        end
        exp_stalls = 0;
        idle(2);
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_lw_beq();
        test_lw_addu();
        test_jal_jr();
        test_youngest_wins();
        test_mdu(2'd1, 5, "mult");
        test_mdu(2'd2, 10, "div");
        test_md_reserved();
        test_zero_and_invalid();
        test_stats();
        test_reset_mid_mult();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/grf_hazard_ctrl.md
Name: grf_hazard_ctrl

Overview:
Hazard scheduler for the 5-stage pipeline's general register file (GRF). It tracks in-flight GRF writes through the E/M/W stages using Tnew countdowns and compares them with the D-stage instruction's source Tuse. From this it drives pipeline stall, E-stage bubble insertion and D-stage forward selects. It also sequences the multi-cycle multiply/divide unit (MDU) busy window so MDU consumers wait until results are ready.

Parameters:
MULT_CYCLES, 5, cycles MDU stays busy after a mult/multu issues
DIV_CYCLES, 10, cycles MDU stays busy after a div/divu issues
CNT_W, 4, width of MDU busy counter; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
d_valid  in  1  D stage holds a real instruction
d_rs  in  5  D source register 1
d_rt  in  5  D source register 2
d_tuse_rs  in  2  cycles until rs is consumed (3 = not used)
d_tuse_rt  in  2  cycles until rt is consumed (3 = not used)
d_wa  in  5  D destination register (0 = no write)
d_tnew  in  2  Tnew of D instruction measured at E entry
d_md_op  in  2  0 none, 1 mult-class, 2 div-class, 3 reserved (treated as none)
d_md_use  in  1  D instruction reads HI/LO or starts MDU
stall  out  1  freeze PC and F/D register
e_flush  out  1  load bubble into D/E register
fwd_rs_sel  out  2  0 GRF, 1 from E, 2 from M
fwd_rt_sel  out  2  same encoding for rt
md_busy  out  1  MDU counter nonzero
stall_cnt  out  32  stall-cycle statistic (see Optional Feature)

Behaviour:
- Reset: all stage entries invalid (wa=0, tnew=0), MDU counter 0. Outputs stall=0, e_flush=0, fwd selects 0, md_busy=0, stall_cnt=0.
- Stage tracking: three registered entries E, M, W, each holding {wa, tnew}. Every posedge:
  - W <= M with tnew decremented, saturating at 0.
  - M <= E with tnew decremented, saturating at 0.
  - E <= {d_wa, d_tnew} if d_valid && !stall; otherwise bubble {0, 0}.
- Data stall: for each source s in {rs, rt}, stall if s != 0 and either:
  - E.wa == s and E.tnew > tuse_s, or
  - M.wa == s and M.tnew > tuse_s.
  - W never stalls; the GRF bypasses same-cycle writes internally.
- MDU stall: stall if d_valid && d_md_use && md_busy.
- stall is the OR of all stall terms, gated by d_valid. e_flush = stall. Both are combinational.
- Forwarding:
  - fwd_x_sel = 1 if E.wa == x != 0 and E.tnew == 0.
  - Else 2 if M.wa == x != 0 and M.tnew == 0.
  - Else 0. The youngest stage wins.
  - Register $0 never forwards and never stalls.
- MDU counter:
  - On a posedge with d_valid && !stall && d_md_op == 1, load MULT_CYCLES; with d_md_op == 2, load DIV_CYCLES.
  - Otherwise decrement if nonzero.
  - md_busy = (cnt != 0). A back-to-back MDU op therefore stalls until cnt reaches 0.
- Simultaneous events: a load and a decrement on the same edge resolve as load. A reset asserted mid-operation clears all entries and the counter on that edge, and stall drops the following cycle.
- Forwarding for consumers with tuse > 0 in later stages is resolved by stage-local muxes and is outside this block.

Optional Feature:
HAZARD_STATS_EN:
- Defined: stall_cnt increments every cycle stall=1, wraps at 2^32, and clears on reset.
- Undefined: stall_cnt is tied to 0 and no counter flops are generated.

Decomposition:
- Shared package: Tuse/Tnew width and "unused" encoding (3), fwd select encodings (GRF=0, E=1, M=2), md_op encodings.
- Natural sub-module: md_busy_timer (counter, load/decrement, md_busy).

Test Plan:
- lw $1 (d_tnew=2), then beq using $1 (tuse_rs=0) -> stall=1 for 2 cycles, then 0; fwd_rs_sel=0 on release.
- lw $1, then addu using $1 (tuse_rs=1) -> exactly 1 stall cycle; e_flush pulses with it.
- jal writing $31 (d_tnew=0), then jr $31 (tuse=0) -> no stall, fwd_rs_sel=1; one cycle later with a nop in between -> fwd_rs_sel=2.
- mult (d_md_op=1), then mflo (d_md_use=1) -> stall for 5 cycles, released when md_busy falls; div then mfhi -> 10 cycles.
- Instruction with d_wa=0 or d_rs=0 matching an in-flight entry -> no stall, fwd selects 0.
- reset asserted during a mult busy window -> md_busy=0 and stall=0 the next cycle; with HAZARD_STATS_EN, stall_cnt=0.
